jk_bank_sequencer: RTL
======================

Name: jk_bank_sequencer

Overview:
Command-driven sequencer for a WIDTH-bit register bank built from JK flip-flops. It accepts one command at a time over a valid/ready handshake: load, count up, count down, or toggle for a programmable number of cycles. For each bit it computes the J/K excitation each cycle, applies it to the internal JK bank, and exposes the excitation vectors for observation. It sits between a control FSM or testbench driver and the flip-flop datapath. It pulses done when a command completes.

Parameters:
WIDTH, 4, number of JK flip-flops in the bank
LEN_W, 8, width of the run-length field

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command; high only in IDLE
cmd_op  input  2  00 LOAD, 01 UP, 10 DOWN, 11 TOGGLE
cmd_data  input  WIDTH  load value; used by LOAD only
cmd_len  input  LEN_W  number of active cycles; ignored by LOAD
hold  input  1  pause request; freezes the bank and the remaining count while in RUN
j_vec  output  WIDTH  J excitation applied this cycle
k_vec  output  WIDTH  K excitation applied this cycle
q  output  WIDTH  bank state
busy  output  1  high in RUN or DONE
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, immediate): state=IDLE, q=0, remaining=0, latched op/data cleared. Outputs: done=0, busy=0, j_vec=k_vec=0. cmd_ready=1 because it is decoded from IDLE; no accept can occur while rst is high.
- Accept: cmd_valid & cmd_ready sampled at a rising edge. The block latches op, data and len.
- Transitions out of IDLE on accept:
  - LOAD: remaining=1, next state RUN.
  - UP/DOWN/TOGGLE with len≠0: remaining=len, next state RUN.
  - UP/DOWN/TOGGLE with len=0: next state DONE; q unchanged.
- RUN with hold=1: j_vec=k_vec=0; q and remaining are frozen.
- RUN with hold=0: excitation is applied per bit, and q updates at the next edge as a JK flop (00 hold, 10 set, 01 reset, 11 toggle).
  - remaining decrements each non-held RUN cycle.
  - When remaining==1 on a non-held cycle, next state is DONE.
- Excitation in RUN with hold=0:
  - LOAD: J=data, K=~data.
  - UP: J[i]=K[i]=AND of q[i-1:0]; bit 0 toggles always.
  - DOWN: J[i]=K[i]=AND of ~q[i-1:0]; bit 0 toggles always.
  - TOGGLE: J=K=all ones.
- Counting wraps modulo 2^WIDTH with no flag.
- DONE: lasts exactly one cycle with done=1, cmd_ready=0, j_vec=k_vec=0, q holds. Next state is IDLE.
- IDLE: j_vec=k_vec=0, q holds, done=0.
- Latency:
  - LOAD: accept edge E0, RUN cycle, q valid after E1, done high E1→E2, cmd_ready high after E2.
  - Count ops: done is asserted after len non-held RUN cycles.
- hold is ignored in IDLE and DONE.
- cmd_valid is ignored outside IDLE. A command held valid across DONE is accepted on the first IDLE edge.
- rst asserted mid-RUN or in DONE: immediate return to the reset values; the command is discarded and no done pulse is issued.
- All arithmetic is unsigned. remaining is LEN_W bits, so the maximum run is 2^LEN_W−1 cycles.

Test Plan:
1. Reset: assert rst mid-cycle → q=0000, busy=0, done=0, cmd_ready=1, j_vec=k_vec=0 without waiting for a clock edge.
2. LOAD, cmd_data=1010 → one RUN cycle with j_vec=1010, k_vec=0101; q=1010 after E1; done for one cycle; cmd_ready high after E2.
3. UP, len=7, from q=1010 → q steps 1011…1111, 0000, 0001 (wraps); done after exactly 7 RUN cycles. Then DOWN, len=3 → q=1110.
4. TOGGLE from q=1110: len=2 → q=1110; len=1 → q=0001. Then UP, len=0 → q unchanged, done on the cycle after accept, no RUN cycle.
5. UP, len=4, with hold high for 3 cycles after the second RUN cycle → q frozen and j_vec=k_vec=0 during hold; done 3 cycles later than the unheld case; final q equals start+4.
6. rst pulsed during the third cycle of UP len=10 → q=0 and state IDLE immediately, no done pulse; the next LOAD 0110 completes normally.

Source files
------------

// File: rtl/jk_bank_sequencer.sv
// Command-driven sequencer for a bank of JK flip-flops: it can load the bank, count up,
// count down, or toggle for a programmed run length, and it exposes the per-bit J/K excitation.
module jk_bank_sequencer #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             hold,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_UP     = 2'b01;
    localparam logic [1:0] OP_DOWN   = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [WIDTH-1:0] VEC_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] VEC_ONES = {WIDTH{1'b1}};

    state_t           state_r, state_next_s;
    logic [WIDTH-1:0] q_r, q_next_s;
    logic [LEN_W-1:0] rem_r, rem_next_s;
    logic [1:0]       op_r, op_next_s;
    logic [WIDTH-1:0] data_r, data_next_s;
    logic [WIDTH-1:0] j_s, k_s;

    // Ripple-carry toggle mask: bit i toggles when every lower bit of 'bits' is set.
    function automatic logic [WIDTH-1:0] carry_mask(input logic [WIDTH-1:0] bits);
        logic acc;
        acc = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            carry_mask[i] = acc;
            acc           = acc & bits[i];
        end
    endfunction

    // JK characteristic equation, applied bitwise.
    function automatic logic [WIDTH-1:0] jk_apply(input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] j,
                                                  input logic [WIDTH-1:0] k);
        jk_apply = (j & ~cur) | (~k & cur);
    endfunction

    // State, bank and command registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            q_r     <= VEC_ZERO;
            rem_r   <= LEN_ZERO;
            op_r    <= 2'b00;
            data_r  <= VEC_ZERO;
        end else begin
            state_r <= state_next_s;
            q_r     <= q_next_s;
            rem_r   <= rem_next_s;
            op_r    <= op_next_s;
            data_r  <= data_next_s;
        end
    end

    // Next-state, excitation and command-latch logic.
    always_comb begin
        state_next_s = state_r;
        q_next_s     = q_r;
        rem_next_s   = rem_r;
        op_next_s    = op_r;
        data_next_s  = data_r;
        j_s          = VEC_ZERO;
        k_s          = VEC_ZERO;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_next_s   = cmd_op;
                    data_next_s = cmd_data;
                    if (cmd_op == OP_LOAD) begin
                        rem_next_s   = LEN_ONE;
                        state_next_s = ST_RUN;
                    end else if (cmd_len != LEN_ZERO) begin
                        rem_next_s   = cmd_len;
                        state_next_s = ST_RUN;
                    end else begin
                        state_next_s = ST_DONE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (hold) begin
                    state_next_s = ST_RUN;
                end else begin
                    case (op_r)
                        OP_LOAD: begin
                            j_s = data_r;
                            k_s = ~data_r;
                        end
                        OP_UP: begin
                            j_s = carry_mask(q_r);
                            k_s = carry_mask(q_r);
                        end
                        OP_DOWN: begin
                            j_s = carry_mask(~q_r);
                            k_s = carry_mask(~q_r);
                        end
                        OP_TOGGLE: begin
                            j_s = VEC_ONES;
                            k_s = VEC_ONES;
                        end
                        default: begin
                            j_s = VEC_ZERO;
                            k_s = VEC_ZERO;
                        end
                    endcase
                    q_next_s   = jk_apply(q_r, j_s, k_s);
                    rem_next_s = rem_r - LEN_ONE;
                    if (rem_r == LEN_ONE) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_r == ST_IDLE);
    assign busy      = (state_r == ST_RUN) || (state_r == ST_DONE);
    assign done      = (state_r == ST_DONE);
    assign q         = q_r;
    assign j_vec     = j_s;
    assign k_vec     = k_s;

endmodule
